// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM input-capture block.
// Contents:
//   state_t      - capture FSM states (IDLE / HIGH / LOW)
//   CNT_W_DEF    - default counter / output width
//   FILT_LEN_DEF - default glitch filter length
//   CNT_SAT_DEF  - counter saturation value for the default width
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEF    = 16;
  localparam int FILT_LEN_DEF = 2;

  // Largest value the cycle counter can hold; also the timeout threshold.
  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its user.
// Signals:
//   en_i      - capture enable (user -> capture)
//   pwm_i     - raw pad input (user -> capture)
//   period_o  - cycles between the last two accepted rising edges
//   high_o    - cycles from that rising edge to the following falling edge
//   valid_o   - one-cycle strobe, period_o/high_o updated this cycle
//   timeout_o - sticky, awaited edge missing for 2^CNT_W-1 cycles
//   level_o   - filtered input level
// Modports: master = user side, slave = capture block.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             en_i;
  logic             pwm_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;
  logic             level_o;

  modport master (
    output en_i, pwm_i,
    input  period_o, high_o, valid_o, timeout_o, level_o
  );

  modport slave (
    input  en_i, pwm_i,
    output period_o, high_o, valid_o, timeout_o, level_o
  );

endinterface

// File: rtl/pwm_glitch_filter.sv
// Pad-input conditioner: 2-FF synchronizer followed by a stability filter.
// The filtered level only follows the synchronized input after it has
// differed from the current level for FILT_LEN consecutive cycles.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_din        - raw asynchronous input
//   o_level      - filtered level
//   o_rise       - one-cycle strobe in the first cycle o_level is 1
//   o_fall       - one-cycle strobe in the first cycle o_level is 0
module pwm_glitch_filter
  import pwm_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // Accept on the FILT_LEN-th consecutive differing cycle.
  localparam logic [3:0] RUN_LIM = 4'(FILT_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_rise;
  logic       r_fall;
  logic [3:0] r_run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_run   <= 4'd0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_run == RUN_LIM) begin
          // Strobes are registered together with the level so they mark
          // the first cycle of the new level.
          r_level <= r_sync2;
          r_run   <= 4'd0;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
        end else begin
          r_run <= r_run + 4'd1;
        end
      end else begin
        r_run <= 4'd0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture receiver: measures period and high time of one
// external PWM waveform and reports each completed measurement with a
// one-cycle valid strobe. Missing edges raise a sticky timeout.
// Ports:
//   wb_clk_i - system clock
//   wb_rst_i - asynchronous active-high reset
//   bus      - pwm_capture_if.slave (en_i, pwm_i in; period_o, high_o,
//              valid_o, timeout_o, level_o out)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_din   (bus.pwm_i),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hpend;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;
  logic             w_sat;
  logic             w_capture;
  logic             w_hold_high;
  logic             w_timeout;

  assign w_sat = (r_cnt == SAT);

  // Cycles since the last rise strobe. The strobe cycle itself is 0, so
  // the register reads 1 in the following cycle; during the next strobe
  // cycle it holds the full period.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= ONE;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An awaited strobe wins over saturation in the same cycle.
  always_comb begin
    w_next = r_state;
    if (!bus.en_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rise) w_next = ST_HIGH;
        ST_HIGH: begin
          if (w_fall)     w_next = ST_LOW;
          else if (w_sat) w_next = ST_IDLE;
        end
        ST_LOW: begin
          if (w_rise)     w_next = ST_HIGH;
          else if (w_sat) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture   = 1'b0;
    w_hold_high = 1'b0;
    w_timeout   = 1'b0;
    if (bus.en_i) begin
      case (r_state)
        ST_HIGH: begin
          w_hold_high = w_fall;
          w_timeout   = !w_fall && w_sat;
        end
        ST_LOW: begin
          w_capture = w_rise;
          w_timeout = !w_rise && w_sat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_hpend   <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_hold_high) begin
        r_hpend <= r_cnt;
      end
      if (w_capture) begin
        r_period  <= r_cnt;
        r_high    <= r_hpend;
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.period_o  = r_period;
  assign bus.high_o    = r_high;
  assign bus.valid_o   = r_valid;
  assign bus.timeout_o = r_timeout;
  assign bus.level_o   = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: unit 0 is CNT_W=16/FILT_LEN=2, unit 1 is
// CNT_W=8/FILT_LEN=1. Every cycle both units are compared against a
// timestamp-based reference model; table entries and hand sequences add
// end-of-phase checks against hand-derived constants.
module tb_pwm_capture;

  localparam int W0 = 16;
  localparam int F0 = 2;
  localparam int W1 = 8;
  localparam int F1 = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(W0)) bus0 ();
  pwm_capture_if #(.CNT_W(W1)) bus1 ();

  pwm_capture #(.CNT_W(W0), .FILT_LEN(F0)) dut0 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus0)
  );

  pwm_capture #(.CNT_W(W1), .FILT_LEN(F1)) dut1 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus1)
  );

  int   checks = 0;
  int   errors = 0;
  int   vcnt [2];
  logic r1_rand;

  // Reference model state, one slot per unit.
  int   m_e [2];
  int   m_run [2];
  int   m_st [2];
  int   m_tr [2];
  int   m_hp [2];
  int   m_per [2];
  int   m_hi [2];
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_lvl [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_val [2];
  logic m_to [2];

  typedef struct {
    int p;
    int h;
    int n;
    int glitch;
    int exp_v;
    int exp_p;
    int exp_h;
  } vec_t;

  vec_t tbl [3];

  function automatic int sat(input int u);
    return (u == 0) ? 65535 : 255;
  endfunction

  function automatic int filt(input int u);
    return (u == 0) ? F0 : F1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_e[u] = 0;   m_run[u] = 0; m_st[u] = 0;  m_tr[u] = 0;
      m_hp[u] = 0;  m_per[u] = 0; m_hi[u] = 0;
      m_s1[u] = 0;  m_s2[u] = 0;  m_lvl[u] = 0;
      m_rise[u] = 0; m_fall[u] = 0; m_val[u] = 0; m_to[u] = 0;
    end
  endtask

  // m_st: 0 = not measuring, 1 = waiting for fall, 2 = waiting for rise.
  // Edge events are timestamped by clock edge index; measurements are
  // differences of timestamps.
  task automatic model_edge(input int u, input logic pwm, input logic en);
    int   c;
    logic old_s2;
    c = m_e[u];
    m_e[u] = m_e[u] + 1;
    m_val[u] = 1'b0;
    if (!en) begin
      m_st[u] = 0;
    end else if (m_st[u] == 0) begin
      if (m_rise[u]) begin
        m_st[u] = 1;
        m_tr[u] = c;
      end
    end else if (m_st[u] == 1) begin
      if (m_fall[u]) begin
        m_hp[u] = c - m_tr[u];
        m_st[u] = 2;
      end else if (c - m_tr[u] >= sat(u)) begin
        m_to[u] = 1'b1;
        m_st[u] = 0;
      end
    end else begin
      if (m_rise[u]) begin
        m_per[u] = (c - m_tr[u] > sat(u)) ? sat(u) : c - m_tr[u];
        m_hi[u]  = m_hp[u];
        m_val[u] = 1'b1;
        m_to[u]  = 1'b0;
        m_tr[u]  = c;
        m_st[u]  = 1;
      end else if (c - m_tr[u] >= sat(u)) begin
        m_to[u] = 1'b1;
        m_st[u] = 0;
      end
    end
    old_s2 = m_s2[u];
    m_s2[u] = m_s1[u];
    m_s1[u] = pwm;
    m_rise[u] = 1'b0;
    m_fall[u] = 1'b0;
    if (old_s2 != m_lvl[u]) begin
      m_run[u] = m_run[u] + 1;
      if (m_run[u] == filt(u)) begin
        m_lvl[u]  = old_s2;
        m_run[u]  = 0;
        m_rise[u] = old_s2;
        m_fall[u] = !old_s2;
      end
    end else begin
      m_run[u] = 0;
    end
  endtask

  task automatic cmp(input int u, input int p, input int h, input logic v,
                     input logic t, input logic l);
    checks++;
    if (p != m_per[u] || h != m_hi[u] || v !== m_val[u] || t !== m_to[u] ||
        l !== m_lvl[u]) begin
      errors++;
      $display("FAIL cycle u%0d e%0d got p=%0d h=%0d v=%0b t=%0b l=%0b exp p=%0d h=%0d v=%0b t=%0b l=%0b",
               u, m_e[u], p, h, v, t, l, m_per[u], m_hi[u], m_val[u], m_to[u], m_lvl[u]);
    end
    if (v === 1'b1) vcnt[u]++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    if (r1_rand) bus1.pwm_i = 1'($urandom_range(1, 0));
    else         bus1.pwm_i = ~bus1.pwm_i;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, bus0.pwm_i, bus0.en_i);
      model_edge(1, bus1.pwm_i, bus1.en_i);
    end
    #1;
    cmp(0, int'(bus0.period_o), int'(bus0.high_o), bus0.valid_o, bus0.timeout_o, bus0.level_o);
    cmp(1, int'(bus1.period_o), int'(bus1.high_o), bus1.valid_o, bus1.timeout_o, bus1.level_o);
  endtask

  // One PWM period on unit 0: high for h cycles (minus an optional
  // one-cycle glitch), enable dropped for el cycles starting at eo.
  task automatic drive_period(input int p, input int h, input int g,
                              input int eo, input int el);
    for (int i = 0; i < p; i++) begin
      bus0.pwm_i = (i < h) && (i != g);
      bus0.en_i  = !(i >= eo && i < eo + el);
      step();
    end
    bus0.en_i = 1'b1;
  endtask

  initial begin
    int v0;
    int v1;
    int p;
    int h;
    int g;
    int eo;
    int el;

    rst        = 1'b1;
    bus0.en_i  = 1'b1;
    bus0.pwm_i = 1'b0;
    bus1.en_i  = 1'b1;
    bus1.pwm_i = 1'b0;
    r1_rand    = 1'b0;
    vcnt[0]    = 0;
    vcnt[1]    = 0;
    model_reset();

    tbl[0] = '{p: 37,  h: 10, n: 3, glitch: -1, exp_v: 2, exp_p: 37,  exp_h: 10};
    tbl[1] = '{p: 100, h: 25, n: 4, glitch: -1, exp_v: 4, exp_p: 100, exp_h: 25};
    tbl[2] = '{p: 100, h: 25, n: 3, glitch: 12, exp_v: 3, exp_p: 100, exp_h: 25};

    repeat (3) step();
    chk("reset_period",  int'(bus0.period_o),  0);
    chk("reset_high",    int'(bus0.high_o),    0);
    chk("reset_valid",   int'(bus0.valid_o),   0);
    chk("reset_timeout", int'(bus0.timeout_o), 0);
    chk("reset_level",   int'(bus0.level_o),   0);
    rst = 1'b0;
    repeat (4) step();

    for (int k = 0; k < 3; k++) begin
      v0 = vcnt[0];
      for (int j = 0; j < tbl[k].n; j++)
        drive_period(tbl[k].p, tbl[k].h, tbl[k].glitch, 0, 0);
      chk($sformatf("tbl%0d_valids", k), vcnt[0] - v0, tbl[k].exp_v);
      chk($sformatf("tbl%0d_period", k), int'(bus0.period_o), tbl[k].exp_p);
      chk($sformatf("tbl%0d_high", k),   int'(bus0.high_o),   tbl[k].exp_h);
      chk($sformatf("tbl%0d_timeout", k), int'(bus0.timeout_o), 0);
    end

    // Input stuck high: the first rise completes a 100/25 period, then
    // the missing fall must time out.
    v0 = vcnt[0];
    for (int i = 0; i < 70000; i++) begin
      if (i == 20) v0 = vcnt[0];
      bus0.pwm_i = 1'b1;
      step();
    end
    chk("hold_valids",  vcnt[0] - v0, 0);
    chk("hold_timeout", int'(bus0.timeout_o), 1);
    chk("hold_level",   int'(bus0.level_o), 1);
    chk("hold_period",  int'(bus0.period_o), 100);
    chk("hold_high",    int'(bus0.high_o), 25);

    v0 = vcnt[0];
    repeat (3) drive_period(200, 50, -1, 0, 0);
    chk("resume_valids",  vcnt[0] - v0, 1);
    chk("resume_period",  int'(bus0.period_o), 200);
    chk("resume_high",    int'(bus0.high_o), 50);
    chk("resume_timeout", int'(bus0.timeout_o), 0);

    // Enable dropped inside a high phase.
    drive_period(120, 40, -1, 0, 0);
    drive_period(120, 40, -1, 0, 0);
    drive_period(120, 40, -1, 15, 10);
    v0 = vcnt[0];
    drive_period(120, 40, -1, 0, 0);
    chk("en_broken_valids", vcnt[0] - v0, 0);
    v0 = vcnt[0];
    drive_period(120, 40, -1, 0, 0);
    chk("en_resume_valids", vcnt[0] - v0, 1);
    chk("en_resume_period", int'(bus0.period_o), 120);
    chk("en_resume_high",   int'(bus0.high_o), 40);

    // Asynchronous reset in the middle of a low phase.
    for (int i = 0; i < 60; i++) begin
      bus0.pwm_i = (i < 40);
      step();
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_period",   int'(bus0.period_o),  0);
    chk("arst_high",     int'(bus0.high_o),    0);
    chk("arst_valid",    int'(bus0.valid_o),   0);
    chk("arst_timeout",  int'(bus0.timeout_o), 0);
    chk("arst_u1_period", int'(bus1.period_o), 0);
    chk("arst_u1_level",  int'(bus1.level_o),  0);
    bus0.pwm_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    v0 = vcnt[0];
    repeat (3) drive_period(10, 3, -1, 0, 0);
    chk("post_rst_valids", vcnt[0] - v0, 2);
    chk("post_rst_period", int'(bus0.period_o), 10);
    chk("post_rst_high",   int'(bus0.high_o), 3);

    // Unit 1 has been toggling every cycle: minimum period 2, high 1.
    v1 = vcnt[1];
    repeat (40) step();
    chk("min_valids", vcnt[1] - v1, 20);
    chk("min_period", int'(bus1.period_o), 2);
    chk("min_high",   int'(bus1.high_o), 1);

    // Random waveforms with occasional glitches and enable drops; unit 1
    // sees random bits.
    r1_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      p  = $urandom_range(60, 8);
      h  = $urandom_range(p - 3, 3);
      g  = ($urandom_range(3, 0) == 0) ? $urandom_range(p - 1, 0) : -1;
      eo = 0;
      el = 0;
      if ($urandom_range(7, 0) == 0) begin
        eo = $urandom_range(p - 1, 0);
        el = $urandom_range(5, 1);
      end
      drive_period(p, h, g, eo, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture receiver for PWM waveforms arriving on a user IO pad. It is the inverse of the PWM generator.
- Measures period and high time of one external PWM signal and presents each completed measurement with a one-cycle valid strobe.
- Sits beside user_proj_pwm inside the user project area. Its input comes from an io_in bit; the wrapper ties the matching io_oeb bit high (input).

Parameters:
- CNT_W, 16, width of period/high counters and outputs; max measurable period 2^CNT_W-1 cycles.
- FILT_LEN, 2, glitch filter length: input must be stable for FILT_LEN consecutive cycles to be accepted (legal range 1..15).

Ports:
- wb_clk_i  input  1  system clock; all logic in this domain.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- en_i  input  1  capture enable; low forces IDLE.
- pwm_i  input  1  raw asynchronous pad input.
- period_o  output  CNT_W  cycles between the last two accepted rising edges.
- high_o  output  CNT_W  cycles from the last accepted rising edge to the following falling edge.
- valid_o  output  1  one-cycle pulse: period_o/high_o updated this cycle.
- timeout_o  output  1  sticky: expected edge not seen within 2^CNT_W-1 cycles.
- level_o  output  1  current filtered input level.

Behaviour:
- Reset values: period_o=0, high_o=0, valid_o=0, timeout_o=0, level_o=0, state=IDLE, sync/filter registers 0.
- Front end: pwm_i passes through a 2-FF synchronizer, then the glitch filter.
  - The filtered level changes only after the synchronized input has differed from it for FILT_LEN consecutive cycles.
  - Rise/fall strobes are generated from the filtered level.
  - Fixed input latency is 2+FILT_LEN cycles. This latency equally delays both edges, so measured values are unaffected.
- Counter: a free-running count of cycles since the last rise strobe; the rise-strobe cycle counts as 0. It saturates at 2^CNT_W-1.
- FSM:
  - IDLE: on rise strobe with en_i=1, clear the counter and go to HIGH. No output update.
  - HIGH: on fall strobe, hold the counter value as pending high time and go to LOW.
  - LOW: on rise strobe, set period_o=counter value and high_o=pending high, assert valid_o the next cycle, clear timeout_o, clear the counter, and go to HIGH.
  - The first rising edge after IDLE therefore only starts measurement; the first valid_o follows the second rising edge.
- Timeout: in HIGH or LOW, if the counter reaches 2^CNT_W-1 before the awaited strobe:
  - set timeout_o and go to IDLE;
  - period_o and high_o keep their last values;
  - no valid_o is issued.
  - This covers 0% and 100% duty; level_o tells the two apart.
- Simultaneous events:
  - A rise strobe in the same cycle as counter saturation counts as a valid edge, not a timeout.
  - Rise and fall strobes cannot coincide, because the filter output changes at most once per cycle.
- en_i deasserted: go to IDLE next cycle; the partial measurement is discarded. Outputs and timeout_o hold their values. Synchronizer and filter keep running, so level_o stays live.
- Async reset mid-measurement returns everything to reset values immediately. The first measurement after reset needs two fresh rising edges.
- Valid values satisfy 1 <= high_o < period_o. high_o = period_o is impossible, since a fall must occur between rises.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encoding (IDLE/HIGH/LOW);
  - default CNT_W;
  - a constant for the saturation value, derived from CNT_W.
- Sub-module pwm_glitch_filter: synchronizer plus stability counter, exposing level, rise and fall outputs. It is reusable for other pad inputs.
- The top level holds the counter, FSM and output registers.

Test Plan:
- CNT_W=16, FILT_LEN=2, en_i=1; drive period 100 cycles with high 25 for 3 periods -> valid_o pulses once per period after the 2nd rising edge; period_o=100, high_o=25 each time; timeout_o=0.
- Same waveform with a 1-cycle low glitch inserted mid-high -> glitch rejected; period_o=100, high_o=25 unchanged.
- Hold pwm_i high for 70000 cycles after one measurement -> timeout_o=1 at counter 65535, level_o=1, no valid_o, period_o/high_o keep 100/25. Then resume a 200/50 waveform -> after two rises, valid_o with 200/50 and timeout_o cleared.
- Drop en_i for 10 cycles in the middle of a high phase -> no valid_o for the broken period. Re-enable -> first valid only after two subsequent rising edges, with correct values.
- Assert wb_rst_i asynchronously mid-LOW phase -> all outputs 0 immediately. After release, a period 10/high 3 waveform gives period_o=10, high_o=3 on the 2nd rise.
- Minimum period at FILT_LEN=1: period 2, high 1 -> period_o=2, high_o=1, valid_o every 2 cycles.
